// File: rtl/seq_pkg.sv
// Shared types and defaults for the serializer and the sequence detector it feeds.
package seq_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  // Line level while no word is shifting; the detector bench relies on the same value.
  localparam logic SER_IDLE_BIT = 1'b0;

  localparam int unsigned SER_WIDTH = 8;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a hold register in front of the shift register,
// so consecutive words stream out at one bit per clock with no gap.
module bit_serializer
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH     = SER_WIDTH,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = SER_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_last,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  if (WIDTH < 2) begin : g_width_check
    $error("bit_serializer: WIDTH must be at least 2");
  end

  ser_state_t       state, state_d;
  logic [WIDTH-1:0] hold, hold_d;
  logic [WIDTH-1:0] shift, shift_d;
  logic             hold_full, hold_full_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             xfer;
  logic             drain;

  assign xfer = s_valid & s_ready;

  // Next-state: drain and transfer never coincide, since drain needs hold full and transfer needs it empty.
  always_comb begin
    state_d     = state;
    hold_d      = hold;
    hold_full_d = hold_full;
    shift_d     = shift;
    cnt_d       = cnt;
    drain       = 1'b0;

    case (state)
      SER_IDLE: begin
        if (hold_full) begin
          drain   = 1'b1;
          state_d = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        if (cnt == '0) begin
          if (hold_full) drain = 1'b1;
          else           state_d = SER_IDLE;
        end else begin
          shift_d = MSB_FIRST ? (shift << 1) : (shift >> 1);
          cnt_d   = cnt - CW'(1);
        end
      end
      default: state_d = SER_IDLE;
    endcase

    if (drain) begin
      shift_d     = hold;
      cnt_d       = CNT_LAST;
      hold_full_d = 1'b0;
    end

    if (xfer) begin
      hold_d      = s_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SER_IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shift     <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_d;
      hold      <= hold_d;
      hold_full <= hold_full_d;
      shift     <= shift_d;
      cnt       <= cnt_d;
    end
  end

  // Outputs decode registered state only; s_ready has no path from the drain.
  assign s_ready    = rst & ~hold_full;
  assign ser_valid  = (state == SER_SHIFT);
  assign ser_out    = ser_valid ? (MSB_FIRST ? shift[WIDTH-1] : shift[0]) : IDLE_BIT;
  assign frame_last = ser_valid & (cnt == '0);
  assign busy       = hold_full | ser_valid;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share stimulus and are
// compared every cycle against a queue-of-bits model of the serial line.
module tb_bit_serializer;
  import seq_pkg::*;

  localparam int unsigned W = 4;
  localparam logic IDLE_M = SER_IDLE_BIT;
  localparam logic IDLE_L = 1'b1;

  logic         clk;
  logic         rst;
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_ready_m, ser_out_m, ser_valid_m, frame_last_m, busy_m;
  logic         s_ready_l, ser_out_l, ser_valid_l, frame_last_l, busy_l;
  logic [9:0]   obs;

  int vectors = 0;
  int miscompares = 0;

  // Model: pending line bits for each order plus the single-word hold slot.
  logic         m_q_m[$];
  logic         m_q_l[$];
  logic [W-1:0] m_hold;
  logic         m_hold_full;
  logic [W-1:0] sent[$];
  logic [W-1:0] rx[$];
  logic [W-1:0] acc;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE_M)) dut_m (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_m),
    .ser_out(ser_out_m), .ser_valid(ser_valid_m), .frame_last(frame_last_m), .busy(busy_m)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE_L)) dut_l (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_l),
    .ser_out(ser_out_l), .ser_valid(ser_valid_l), .frame_last(frame_last_l), .busy(busy_l)
  );

  assign obs = {s_ready_m, ser_out_m, ser_valid_m, frame_last_m, busy_m,
                s_ready_l, ser_out_l, ser_valid_l, frame_last_l, busy_l};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rebuild words from the MSB-first line for the loss/duplication scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1 && ser_valid_m === 1'b1) begin
      acc = {acc[W-2:0], ser_out_m};
      if (frame_last_m === 1'b1) rx.push_back(acc);
    end
  end

  function automatic logic [9:0] exp_vec();
    logic sr, nv;
    sr = rst & ~m_hold_full;
    nv = (m_q_m.size() != 0);
    exp_vec = {sr, nv ? m_q_m[0] : IDLE_M, nv, nv & (m_q_m.size() == 1), m_hold_full | nv,
               sr, nv ? m_q_l[0] : IDLE_L, nv, nv & (m_q_l.size() == 1), m_hold_full | nv};
  endfunction

  task automatic model_reset();
    m_q_m.delete();
    m_q_l.delete();
    m_hold      = '0;
    m_hold_full = 1'b0;
  endtask

  // One clock: drive inputs, advance the model across the edge, settle for sampling.
  task automatic tick(input logic v, input logic [W-1:0] d, output logic took);
    logic xfer;
    s_valid = v;
    s_data  = d;
    xfer    = v & rst & ~m_hold_full;
    @(posedge clk);
    if (rst) begin
      if (m_q_m.size() != 0) begin
        void'(m_q_m.pop_front());
        void'(m_q_l.pop_front());
      end
      if (m_q_m.size() == 0 && m_hold_full) begin
        for (int i = 0; i < W; i++) begin
          m_q_m.push_back(m_hold[W-1-i]);
          m_q_l.push_back(m_hold[i]);
        end
        m_hold_full = 1'b0;
      end
      if (xfer) begin
        m_hold      = d;
        m_hold_full = 1'b1;
        sent.push_back(d);
      end
    end
    took = xfer;
    #1;
  endtask

  task automatic test_reset();
    logic took;
    s_valid = 1'b0;
    s_data  = '0;
    rst     = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_async obs=%b exp=%b", obs, exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, W'($urandom), took);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d obs=%b exp=%b", i, obs, exp_vec());
      end
    end
    rst = 1'b1;
    s_valid = 1'b0;
    #1;
    vectors++;
    if (obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_release obs=%b exp=%b", obs, exp_vec());
    end
  endtask

  task automatic test_single_word();
    logic         took;
    logic [W-1:0] stream;
    int           nvalid, lastpos;
    stream = '0;
    nvalid = 0;
    lastpos = 0;
    for (int i = 0; i < 7; i++) begin
      tick(i == 0, 4'b1010, took);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL single_word cyc=%0d obs=%b exp=%b", i, obs, exp_vec());
      end
      if (ser_valid_m) begin
        stream = {stream[W-2:0], ser_out_m};
        nvalid++;
        if (frame_last_m) lastpos = nvalid;
      end
    end
    vectors++;
    if (stream !== 4'b1010 || nvalid != 4 || lastpos != 4) begin
      miscompares++;
      $display("FAIL single_word_stream got=%b/%0d/%0d exp=1010/4/4", stream, nvalid, lastpos);
    end
  endtask

  task automatic test_bit_order();
    logic         took;
    logic [W-1:0] stream;
    stream = '0;
    for (int i = 0; i < 7; i++) begin
      tick(i == 0, 4'b0011, took);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL bit_order cyc=%0d obs=%b exp=%b", i, obs, exp_vec());
      end
      if (ser_valid_l) stream = {stream[W-2:0], ser_out_l};
    end
    vectors++;
    if (stream !== 4'b1100) begin
      miscompares++;
      $display("FAIL bit_order_stream got=%b exp=1100", stream);
    end
  endtask

  task automatic test_back_to_back();
    logic         took;
    logic [W-1:0] pend[$];
    logic [7:0]   stream;
    int           nvalid, first, last;
    pend = '{4'hA, 4'h5};
    stream = '0;
    nvalid = 0;
    first = -1;
    last = -1;
    for (int i = 0; i < 14; i++) begin
      tick(pend.size() != 0, (pend.size() != 0) ? pend[0] : '0, took);
      if (took) void'(pend.pop_front());
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL back_to_back cyc=%0d obs=%b exp=%b", i, obs, exp_vec());
      end
      if (ser_valid_m) begin
        stream = {stream[6:0], ser_out_m};
        nvalid++;
        if (first < 0) first = i;
        last = i;
      end
    end
    vectors++;
    if (stream !== 8'b10100101 || nvalid != 8 || (last - first + 1) != 8) begin
      miscompares++;
      $display("FAIL back_to_back_stream got=%b n=%0d span=%0d exp=10100101 n=8 span=8",
               stream, nvalid, last - first + 1);
    end
  endtask

  task automatic test_backpressure();
    logic         took;
    logic [W-1:0] pend[$];
    sent.delete();
    rx.delete();
    for (int k = 0; k < 3; k++) pend.push_back(W'($urandom));
    for (int i = 0; i < 20; i++) begin
      tick(pend.size() != 0, (pend.size() != 0) ? pend[0] : '0, took);
      if (took) void'(pend.pop_front());
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL backpressure cyc=%0d obs=%b exp=%b", i, obs, exp_vec());
      end
    end
    vectors++;
    if (rx.size() != 3 || sent.size() != 3) begin
      miscompares++;
      $display("FAIL backpressure_count rx=%0d sent=%0d exp=3", rx.size(), sent.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (rx[k] !== sent[k]) begin
          miscompares++;
          $display("FAIL backpressure_word idx=%0d got=%h exp=%h", k, rx[k], sent[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic took;
    for (int i = 0; i < 3; i++) begin
      tick(i == 0, 4'hA, took);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL mid_reset_pre cyc=%0d obs=%b exp=%b", i, obs, exp_vec());
      end
    end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (obs !== exp_vec() || ser_out_m !== IDLE_M || ser_out_l !== IDLE_L) begin
      miscompares++;
      $display("FAIL mid_reset_async obs=%b exp=%b", obs, exp_vec());
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, W'($urandom), took);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL mid_reset_held cyc=%0d obs=%b exp=%b", i, obs, exp_vec());
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, W'($urandom), took);
      vectors++;
      if (obs !== exp_vec() || ser_valid_m !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_reset_after cyc=%0d obs=%b exp=%b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_idle_gap();
    logic took;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 8; i++) begin
        tick(i == 0, W'($urandom), took);
        vectors++;
        if (obs !== exp_vec()) begin
          miscompares++;
          $display("FAIL idle_gap word=%0d cyc=%0d obs=%b exp=%b", w, i, obs, exp_vec());
        end
      end
    end
  endtask

  task automatic test_random();
    logic took;
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 3) != 0, W'($urandom), took);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc=%0d obs=%b exp=%b", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    acc = '0;
    test_reset();
    test_single_word();
    test_bit_order();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_idle_gap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
